mux_key_table: RTL and testbench

Programmable, registered key-to-data lookup table: the successor to the combinational key mux, with NR_KEY runtime-writable (key, data) entries, per-entry valid bits, lowest-index priority on multiple hits, a default value on miss, and a valid/ready request/response handshake with a one-entry output buffer. It sits between a decode stage that produces a selector key and a consumer that needs the mapped value, hit flag and matching index. It also keeps a saturating miss counter for debug.

---
 rtl/mux_key_table_if.sv | 27 ++
 rtl/mux_key_table.sv | 136 +++++++++++++
 tb/tb_mux_key_table.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mux_key_table_if.sv
// Request/response bus of the key lookup table.
// The master is the requester/consumer; the slave is the table.
interface mux_key_table_if #(
  parameter int unsigned KEY_LEN  = 2,
  parameter int unsigned DATA_LEN = 2,
  parameter int unsigned IDX_LEN  = 2
);
  logic                req_valid;
  logic                req_ready;
  logic [KEY_LEN-1:0]  req_key;
  logic [DATA_LEN-1:0] default_out;
  logic                resp_valid;
  logic                resp_ready;
  logic [DATA_LEN-1:0] resp_data;
  logic                resp_hit;
  logic [IDX_LEN-1:0]  resp_idx;

  modport master (
    output req_valid, req_key, default_out, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_hit, resp_idx
  );

  modport slave (
    input  req_valid, req_key, default_out, resp_ready,
    output req_ready, resp_valid, resp_data, resp_hit, resp_idx
  );
endinterface

// File: rtl/mux_key_table.sv
// Programmable key-to-data lookup table with lowest-index priority, a
// one-entry registered response buffer and a saturating miss counter.
module mux_key_table #(
  parameter int unsigned NR_KEY   = 4,
  parameter int unsigned KEY_LEN  = 2,
  parameter int unsigned DATA_LEN = 2,
  parameter int unsigned CNT_LEN  = 8,
  localparam int unsigned IDX_LEN = $clog2(NR_KEY)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [IDX_LEN-1:0]  wr_idx,
  input  logic                wr_vld,
  input  logic [KEY_LEN-1:0]  wr_key,
  input  logic [DATA_LEN-1:0] wr_data,
  input  logic                clr_all,
  mux_key_table_if.slave      bus,
  output logic [CNT_LEN-1:0]  miss_cnt
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [NR_KEY-1:0]   vld_q, vld_d;
  logic [KEY_LEN-1:0]  key_q  [NR_KEY];
  logic [KEY_LEN-1:0]  key_d  [NR_KEY];
  logic [DATA_LEN-1:0] data_q [NR_KEY];
  logic [DATA_LEN-1:0] data_d [NR_KEY];

  logic [0:0]          state_q, state_d;
  logic [DATA_LEN-1:0] resp_data_q, resp_data_d;
  logic                resp_hit_q, resp_hit_d;
  logic [IDX_LEN-1:0]  resp_idx_q, resp_idx_d;
  logic [CNT_LEN-1:0]  miss_cnt_q, miss_cnt_d;

  logic                req_ready_c;
  logic                accept_c;
  logic                wr_ok_c;
  logic                hit_c;
  logic [IDX_LEN-1:0]  idx_c;
  logic [DATA_LEN-1:0] data_c;

  assign req_ready_c = (state_q == ST_EMPTY) || bus.resp_ready;
  assign accept_c    = bus.req_valid && req_ready_c;
  assign wr_ok_c     = wr_en && (32'(wr_idx) < 32'(NR_KEY));

  // Match against pre-edge table contents; scanning downward leaves the lowest hit.
  always_comb begin
    hit_c  = 1'b0;
    idx_c  = '0;
    data_c = bus.default_out;
    for (int i = int'(NR_KEY) - 1; i >= 0; i--) begin
      if (vld_q[i] && (key_q[i] == bus.req_key)) begin
        hit_c  = 1'b1;
        idx_c  = IDX_LEN'(i);
        data_c = data_q[i];
      end
    end
  end

  // Table update: clr_all wins over a same-cycle write and keeps key/data.
  always_comb begin
    vld_d  = vld_q;
    key_d  = key_q;
    data_d = data_q;
    if (clr_all) begin
      vld_d = '0;
    end else if (wr_ok_c) begin
      vld_d[wr_idx]  = wr_vld;
      key_d[wr_idx]  = wr_key;
      data_d[wr_idx] = wr_data;
    end
  end

  // Response buffer state and payload capture.
  always_comb begin
    state_d     = state_q;
    resp_data_d = resp_data_q;
    resp_hit_d  = resp_hit_q;
    resp_idx_d  = resp_idx_q;
    miss_cnt_d  = miss_cnt_q;

    case (state_q)
      ST_EMPTY: begin
        if (accept_c) state_d = ST_FULL;
      end
      ST_FULL: begin
        if (accept_c)            state_d = ST_FULL;
        else if (bus.resp_ready) state_d = ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase

    if (accept_c) begin
      resp_data_d = data_c;
      resp_hit_d  = hit_c;
      resp_idx_d  = idx_c;
      if (!hit_c && (miss_cnt_q != '1)) begin
        miss_cnt_d = miss_cnt_q + CNT_LEN'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < int'(NR_KEY); i++) begin
        key_q[i]  <= '0;
        data_q[i] <= '0;
      end
      state_q     <= ST_EMPTY;
      resp_data_q <= '0;
      resp_hit_q  <= 1'b0;
      resp_idx_q  <= '0;
      miss_cnt_q  <= '0;
    end else begin
      vld_q       <= vld_d;
      key_q       <= key_d;
      data_q      <= data_d;
      state_q     <= state_d;
      resp_data_q <= resp_data_d;
      resp_hit_q  <= resp_hit_d;
      resp_idx_q  <= resp_idx_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  assign bus.req_ready  = req_ready_c;
  assign bus.resp_valid = (state_q == ST_FULL);
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_hit   = resp_hit_q;
  assign bus.resp_idx   = resp_idx_q;
  assign miss_cnt       = miss_cnt_q;

endmodule

// File: tb/tb_mux_key_table.sv
// Bench for mux_key_table: directed scenarios plus a randomized run, all
// checked against a table/queue-level reference model.
module tb_mux_key_table;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [1:0] wr_idx;
  logic       wr_vld;
  logic [1:0] wr_key;
  logic [1:0] wr_data;
  logic       clr_all;
  logic [7:0] miss_cnt;

  mux_key_table_if #(.KEY_LEN(2), .DATA_LEN(2), .IDX_LEN(2)) bus ();

  mux_key_table #(.NR_KEY(4), .KEY_LEN(2), .DATA_LEN(2), .CNT_LEN(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_idx   (wr_idx),
    .wr_vld   (wr_vld),
    .wr_key   (wr_key),
    .wr_data  (wr_data),
    .clr_all  (clr_all),
    .bus      (bus),
    .miss_cnt (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model
  bit         m_vld  [4];
  logic [1:0] m_key  [4];
  logic [1:0] m_data [4];
  int         m_cnt;
  logic       e_valid;
  logic [1:0] e_data;
  logic       e_hit;
  logic [1:0] e_idx;

  task automatic drive_idle();
    wr_en = 1'b0; wr_idx = '0; wr_vld = 1'b0; wr_key = '0; wr_data = '0;
    clr_all = 1'b0;
    bus.req_valid = 1'b0; bus.req_key = '0; bus.default_out = '0;
    bus.resp_ready = 1'b1;
  endtask

  task automatic set_write(input logic [1:0] idx, input logic v,
                           input logic [1:0] k, input logic [1:0] d);
    wr_en = 1'b1; wr_idx = idx; wr_vld = v; wr_key = k; wr_data = d;
  endtask

  // Advance one clock, updating the model from the inputs seen at that edge.
  task automatic tick();
    logic       acc, h;
    logic [1:0] d, ix;
    acc = bus.req_valid && (!e_valid || bus.resp_ready) && !rst;
    h = 1'b0; d = bus.default_out; ix = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!h && m_vld[i] && (m_key[i] == bus.req_key)) begin
        h = 1'b1; d = m_data[i]; ix = 2'(i);
      end
    end
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        m_vld[i] = 1'b0; m_key[i] = '0; m_data[i] = '0;
      end
      m_cnt = 0; e_valid = 1'b0; e_data = '0; e_hit = 1'b0; e_idx = '0;
    end else begin
      if (acc) begin
        e_valid = 1'b1; e_data = d; e_hit = h; e_idx = ix;
        if (!h && m_cnt < 255) m_cnt++;
      end else if (bus.resp_ready) begin
        e_valid = 1'b0;
      end
      if (clr_all) begin
        for (int i = 0; i < 4; i++) m_vld[i] = 1'b0;
      end else if (wr_en) begin
        m_vld[wr_idx] = wr_vld; m_key[wr_idx] = wr_key; m_data[wr_idx] = wr_data;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.resp_ready = 1'b0;
    #1;
    n_cmp++;
    if ({bus.resp_valid, bus.resp_hit, bus.resp_idx, bus.resp_data} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_resp got v%0b h%0b i%0d d%0d want all 0",
               bus.resp_valid, bus.resp_hit, bus.resp_idx, bus.resp_data);
    end
    n_cmp++;
    if (miss_cnt !== 8'd0) begin
      n_err++; $display("FAIL reset_miss_cnt got %0d want 0", miss_cnt);
    end
    n_cmp++;
    if (bus.req_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_req_ready got %0b want 1", bus.req_ready);
    end
    drive_idle();
  endtask

  task automatic test_basic_lookup();
    for (int i = 0; i < 4; i++) begin
      set_write(2'(i), 1'b1, 2'(i), 2'(3 - i));
      tick();
    end
    drive_idle();
    bus.req_valid = 1'b1; bus.req_key = 2'd2;
    tick();
    bus.req_valid = 1'b0;
    n_cmp++;
    if ({bus.resp_valid, bus.resp_hit, bus.resp_idx, bus.resp_data} !== {1'b1, 1'b1, 2'd2, 2'd1}) begin
      n_err++;
      $display("FAIL basic_key2 got v%0b h%0b i%0d d%0d want v1 h1 i2 d1",
               bus.resp_valid, bus.resp_hit, bus.resp_idx, bus.resp_data);
    end
    tick();
    n_cmp++;
    if (bus.resp_valid !== 1'b0) begin
      n_err++; $display("FAIL basic_drain got v%0b want v0", bus.resp_valid);
    end
  endtask

  task automatic test_priority();
    set_write(2'd1, 1'b1, 2'd1, 2'd2); tick();
    set_write(2'd3, 1'b1, 2'd1, 2'd0); tick();
    drive_idle();
    bus.req_valid = 1'b1; bus.req_key = 2'd1;
    tick();
    bus.req_valid = 1'b0;
    n_cmp++;
    if ({bus.resp_valid, bus.resp_hit, bus.resp_idx, bus.resp_data} !== {1'b1, 1'b1, 2'd1, 2'd2}) begin
      n_err++;
      $display("FAIL priority_key1 got v%0b h%0b i%0d d%0d want v1 h1 i1 d2",
               bus.resp_valid, bus.resp_hit, bus.resp_idx, bus.resp_data);
    end
    tick();
  endtask

  task automatic test_miss_saturate();
    clr_all = 1'b1; tick(); drive_idle();
    bus.req_valid = 1'b1; bus.req_key = 2'd0; bus.default_out = 2'd3;
    tick();
    n_cmp++;
    if ({bus.resp_valid, bus.resp_hit, bus.resp_idx, bus.resp_data} !== {1'b1, 1'b0, 2'd0, 2'd3}) begin
      n_err++;
      $display("FAIL miss_first got v%0b h%0b i%0d d%0d want v1 h0 i0 d3",
               bus.resp_valid, bus.resp_hit, bus.resp_idx, bus.resp_data);
    end
    n_cmp++;
    if (miss_cnt !== 8'd1) begin
      n_err++; $display("FAIL miss_cnt_first got %0d want 1", miss_cnt);
    end
    for (int i = 0; i < 300; i++) begin
      bus.req_key = 2'($urandom_range(0, 3));
      tick();
    end
    bus.req_valid = 1'b0;
    n_cmp++;
    if (miss_cnt !== 8'd255) begin
      n_err++; $display("FAIL miss_cnt_sat got %0d want 255", miss_cnt);
    end
    tick();
    n_cmp++;
    if (miss_cnt !== 8'(m_cnt)) begin
      n_err++; $display("FAIL miss_cnt_hold got %0d want %0d", miss_cnt, m_cnt);
    end
  endtask

  task automatic test_read_before_write();
    set_write(2'd0, 1'b1, 2'd0, 2'd3); tick(); drive_idle();
    set_write(2'd0, 1'b1, 2'd0, 2'd1);
    bus.req_valid = 1'b1; bus.req_key = 2'd0;
    tick();
    wr_en = 1'b0;
    n_cmp++;
    if ({bus.resp_hit, bus.resp_data} !== {1'b1, 2'd3}) begin
      n_err++; $display("FAIL rbw_old got h%0b d%0d want h1 d3", bus.resp_hit, bus.resp_data);
    end
    tick();
    n_cmp++;
    if ({bus.resp_hit, bus.resp_data} !== {1'b1, 2'd1}) begin
      n_err++; $display("FAIL rbw_new got h%0b d%0d want h1 d1", bus.resp_hit, bus.resp_data);
    end
    // clr_all with a competing write: lookup sees old table, write is dropped
    clr_all = 1'b1; set_write(2'd0, 1'b1, 2'd0, 2'd2); bus.default_out = 2'd3;
    tick();
    clr_all = 1'b0; wr_en = 1'b0;
    n_cmp++;
    if ({bus.resp_hit, bus.resp_data} !== {1'b1, 2'd1}) begin
      n_err++; $display("FAIL clr_rbw got h%0b d%0d want h1 d1", bus.resp_hit, bus.resp_data);
    end
    tick();
    bus.req_valid = 1'b0;
    n_cmp++;
    if ({bus.resp_hit, bus.resp_idx, bus.resp_data} !== {1'b0, 2'd0, 2'd3}) begin
      n_err++;
      $display("FAIL clr_override got h%0b i%0d d%0d want h0 i0 d3",
               bus.resp_hit, bus.resp_idx, bus.resp_data);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [5:0] held;
    for (int i = 0; i < 4; i++) begin
      set_write(2'(i), 1'b1, 2'(i), 2'(i)); tick();
    end
    drive_idle();
    bus.req_valid = 1'b1; bus.req_key = 2'd3; bus.resp_ready = 1'b0;
    tick();
    held = {bus.resp_valid, bus.resp_hit, bus.resp_idx, bus.resp_data};
    n_cmp++;
    if (held !== {1'b1, 1'b1, 2'd3, 2'd3}) begin
      n_err++; $display("FAIL bp_first got %b want 111111", held);
    end
    bus.req_key = 2'd1;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_cmp++;
      if (bus.req_ready !== 1'b0) begin
        n_err++; $display("FAIL bp_req_ready cycle %0d got %0b want 0", c, bus.req_ready);
      end
      tick();
      n_cmp++;
      if ({bus.resp_valid, bus.resp_hit, bus.resp_idx, bus.resp_data} !== held) begin
        n_err++;
        $display("FAIL bp_stable cycle %0d got %b want %b", c,
                 {bus.resp_valid, bus.resp_hit, bus.resp_idx, bus.resp_data}, held);
      end
    end
    bus.resp_ready = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    n_cmp++;
    if ({bus.resp_valid, bus.resp_hit, bus.resp_idx, bus.resp_data} !== {1'b1, 1'b1, 2'd1, 2'd1}) begin
      n_err++;
      $display("FAIL bp_next got v%0b h%0b i%0d d%0d want v1 h1 i1 d1",
               bus.resp_valid, bus.resp_hit, bus.resp_idx, bus.resp_data);
    end
    tick();
    n_cmp++;
    if (bus.resp_valid !== 1'b0) begin
      n_err++; $display("FAIL bp_no_dup got v%0b want v0", bus.resp_valid);
    end
  endtask

  task automatic test_reset_mid();
    drive_idle();
    bus.req_valid = 1'b1; bus.req_key = 2'd2; bus.resp_ready = 1'b0;
    tick();
    bus.req_valid = 1'b0;
    rst = 1'b1;
    set_write(2'd0, 1'b1, 2'd0, 2'd2);
    bus.req_valid = 1'b1; bus.req_key = 2'd0;
    tick();
    rst = 1'b0; wr_en = 1'b0; bus.req_valid = 1'b0; bus.resp_ready = 1'b1;
    n_cmp++;
    if ({bus.resp_valid, miss_cnt} !== 9'd0) begin
      n_err++; $display("FAIL rst_mid got v%0b cnt %0d want v0 cnt 0", bus.resp_valid, miss_cnt);
    end
    bus.req_valid = 1'b1; bus.req_key = 2'd0; bus.default_out = 2'd1;
    tick();
    bus.req_valid = 1'b0;
    n_cmp++;
    if ({bus.resp_valid, bus.resp_hit, bus.resp_idx, bus.resp_data, miss_cnt} !==
        {1'b1, 1'b0, 2'd0, 2'd1, 8'd1}) begin
      n_err++;
      $display("FAIL rst_mid_lookup got v%0b h%0b i%0d d%0d cnt %0d want v1 h0 i0 d1 cnt 1",
               bus.resp_valid, bus.resp_hit, bus.resp_idx, bus.resp_data, miss_cnt);
    end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_idx  = 2'($urandom_range(0, 3));
      wr_vld  = ($urandom_range(0, 4) != 0);
      wr_key  = 2'($urandom_range(0, 3));
      wr_data = 2'($urandom_range(0, 3));
      clr_all = ($urandom_range(0, 19) == 0);
      bus.req_valid   = ($urandom_range(0, 3) != 0);
      bus.req_key     = 2'($urandom_range(0, 3));
      bus.default_out = 2'($urandom_range(0, 3));
      bus.resp_ready  = ($urandom_range(0, 3) != 0);
      #1;
      n_cmp++;
      if (bus.req_ready !== (!e_valid || bus.resp_ready)) begin
        n_err++;
        $display("FAIL rand_req_ready cycle %0d got %0b want %0b", c, bus.req_ready,
                 (!e_valid || bus.resp_ready));
      end
      tick();
      n_cmp++;
      if (bus.resp_valid !== e_valid ||
          (e_valid && {bus.resp_hit, bus.resp_idx, bus.resp_data} !== {e_hit, e_idx, e_data})) begin
        n_err++;
        $display("FAIL rand_resp cycle %0d got v%0b h%0b i%0d d%0d want v%0b h%0b i%0d d%0d", c,
                 bus.resp_valid, bus.resp_hit, bus.resp_idx, bus.resp_data,
                 e_valid, e_hit, e_idx, e_data);
      end
      n_cmp++;
      if (miss_cnt !== 8'(m_cnt)) begin
        n_err++; $display("FAIL rand_miss_cnt cycle %0d got %0d want %0d", c, miss_cnt, m_cnt);
      end
    end
    drive_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    drive_idle();
    rst = 1'b1;
    m_cnt = 0; e_valid = 1'b0; e_data = '0; e_hit = 1'b0; e_idx = '0;
    for (int i = 0; i < 4; i++) begin
      m_vld[i] = 1'b0; m_key[i] = '0; m_data[i] = '0;
    end
    @(posedge clk);
    #1;
    test_reset();
    test_basic_lookup();
    test_priority();
    test_miss_saturate();
    test_read_before_write();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
